// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding / load-use hazard unit.
package fwd_pkg;

  typedef enum logic {IDLE, WAIT} fwd_state_t;

  localparam int ZERO_REG_DEF = 31;

  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] n;
    n = '0;
    for (int b = 0; b < 32; b++) begin
      n = n + {31'd0, v[b]};
    end
    return n;
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Per-source-operand forwarding selector: compares one source address against all
// write stages and picks the youngest eligible match, flagging load-blocked matches.
module fwd_port_sel
  import fwd_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int REG_W    = 5,
  parameter int NUM_FWD  = 3,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int IDX_W    = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1
) (
  input  logic [REG_W-1:0]          src_addr,
  input  logic                      src_used,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]        stg_wr_en,
  input  logic [NUM_FWD*REG_W-1:0]  stg_wr_addr,
  input  logic [NUM_FWD*DATA_W-1:0] stg_wr_data,
  input  logic [NUM_FWD-1:0]        load_block,
  output logic [DATA_W-1:0]         data,
  output logic                      hit,
  output logic                      hazard,
  output logic [IDX_W-1:0]          hazard_idx
);

  logic [NUM_FWD-1:0] match;
  logic               not_zero;

  assign not_zero = (src_addr != REG_W'(ZERO_REG));

  always_comb begin
    for (int k = 0; k < NUM_FWD; k++) begin
      match[k] = src_used & stg_wr_en[k] & not_zero &
                 (stg_wr_addr[k*REG_W +: REG_W] == src_addr);
    end
  end

  // Walk oldest to youngest so the lowest matching stage overrides the rest.
  always_comb begin
    data       = rf_data;
    hit        = 1'b0;
    hazard     = 1'b0;
    hazard_idx = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (match[k]) begin
        if (load_block[k]) begin
          hazard     = 1'b1;
          hazard_idx = IDX_W'(k);
        end else begin
          hit  = 1'b1;
          data = stg_wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding plus load-use stall FSM. Optional saturating statistics
// counters are built only when FWD_STATS_EN is defined; otherwise they read 0.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int REG_W    = 5,
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 3,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_W-1:0]  id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*DATA_W-1:0] rf_data,
  input  logic [NUM_FWD-1:0]        stg_wr_en,
  input  logic [NUM_FWD*REG_W-1:0]  stg_wr_addr,
  input  logic [NUM_FWD*DATA_W-1:0] stg_wr_data,
  input  logic [NUM_FWD-1:0]        stg_is_load,
  input  logic                      flush,
  output logic [NUM_SRC*DATA_W-1:0] fwd_data,
  output logic [NUM_SRC-1:0]        fwd_hit,
  output logic                      stall,
  output logic                      bubble,
  output logic [31:0]               stat_fwd_cnt,
  output logic [31:0]               stat_stall_cnt
);

  localparam int IDX_W = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;
  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  logic [NUM_FWD-1:0] load_block;
  logic [NUM_SRC-1:0] port_haz;
  logic [IDX_W-1:0]   port_idx [NUM_SRC];
  logic [IDX_W-1:0]   haz_idx;
  logic               hazard;
  logic [CNT_W-1:0]   load_cnt;
  logic [CNT_W-1:0]   cnt;
  fwd_state_t         state;

  always_comb begin
    for (int k = 0; k < NUM_FWD; k++) begin
      load_block[k] = stg_is_load[k] & (k < LOAD_LAT);
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
    fwd_port_sel #(
      .DATA_W   (DATA_W),
      .REG_W    (REG_W),
      .NUM_FWD  (NUM_FWD),
      .ZERO_REG (ZERO_REG),
      .IDX_W    (IDX_W)
    ) u_sel (
      .src_addr    (id_src_addr[i*REG_W +: REG_W]),
      .src_used    (id_src_used[i]),
      .rf_data     (rf_data[i*DATA_W +: DATA_W]),
      .stg_wr_en   (stg_wr_en),
      .stg_wr_addr (stg_wr_addr),
      .stg_wr_data (stg_wr_data),
      .load_block  (load_block),
      .data        (fwd_data[i*DATA_W +: DATA_W]),
      .hit         (fwd_hit[i]),
      .hazard      (port_haz[i]),
      .hazard_idx  (port_idx[i])
    );
  end

  // The youngest blocking load across all operands sets the longest stall.
  always_comb begin
    haz_idx = IDX_W'(NUM_FWD - 1);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (port_haz[i] && (port_idx[i] < haz_idx)) haz_idx = port_idx[i];
    end
  end

  assign hazard   = id_valid & (|port_haz);
  assign load_cnt = CNT_W'(LOAD_LAT - 1 - int'(haz_idx));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hazard) begin
            cnt <= load_cnt;
            if (load_cnt != '0) state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall must drop in the same cycle as flush or an asserted reset.
  assign stall  = reset & ~flush & ((state == WAIT) | hazard);
  assign bubble = stall;

`ifdef FWD_STATS_EN
  logic [31:0] fwd_cnt_q;
  logic [31:0] stall_cnt_q;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (id_valid && !stall) fwd_cnt_q <= sat_add(fwd_cnt_q, popcount(32'(fwd_hit)));
      if (stall) stall_cnt_q <= sat_add(stall_cnt_q, 32'd1);
    end
  end

  assign stat_fwd_cnt   = fwd_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  assign stat_fwd_cnt   = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: one unit with LOAD_LAT=1 and one with LOAD_LAT=2 share the same stimulus.
module tb_fwd_hazard_unit;

  localparam int DW = 64;
  localparam int RW = 5;
  localparam int NS = 2;
  localparam int NF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             id_valid;
  logic [NS*RW-1:0] id_src_addr;
  logic [NS-1:0]    id_src_used;
  logic [NS*DW-1:0] rf_data;
  logic [NF-1:0]    stg_wr_en;
  logic [NF*RW-1:0] stg_wr_addr;
  logic [NF*DW-1:0] stg_wr_data;
  logic [NF-1:0]    stg_is_load;
  logic             flush;

  logic [NS*DW-1:0] d1_data, d2_data;
  logic [NS-1:0]    d1_hit, d2_hit;
  logic             d1_stall, d2_stall, d1_bubble, d2_bubble;
  logic [31:0]      d1_fcnt, d1_scnt, d2_fcnt, d2_scnt;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit #(.DATA_W(DW), .REG_W(RW), .NUM_SRC(NS), .NUM_FWD(NF),
                    .LOAD_LAT(1), .ZERO_REG(31)) u_dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .rf_data(rf_data), .stg_wr_en(stg_wr_en),
    .stg_wr_addr(stg_wr_addr), .stg_wr_data(stg_wr_data), .stg_is_load(stg_is_load),
    .flush(flush), .fwd_data(d1_data), .fwd_hit(d1_hit), .stall(d1_stall),
    .bubble(d1_bubble), .stat_fwd_cnt(d1_fcnt), .stat_stall_cnt(d1_scnt));

  fwd_hazard_unit #(.DATA_W(DW), .REG_W(RW), .NUM_SRC(NS), .NUM_FWD(NF),
                    .LOAD_LAT(2), .ZERO_REG(31)) u_dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .rf_data(rf_data), .stg_wr_en(stg_wr_en),
    .stg_wr_addr(stg_wr_addr), .stg_wr_data(stg_wr_data), .stg_is_load(stg_is_load),
    .flush(flush), .fwd_data(d2_data), .fwd_hit(d2_hit), .stall(d2_stall),
    .bubble(d2_bubble), .stat_fwd_cnt(d2_fcnt), .stat_stall_cnt(d2_scnt));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_valid    = 1'b0;
    id_src_addr = '0;
    id_src_used = '0;
    rf_data     = '0;
    stg_wr_en   = '0;
    stg_wr_addr = '0;
    stg_wr_data = '0;
    stg_is_load = '0;
    flush       = 1'b0;
  endtask

  task automatic set_src(input int i, input logic used, input logic [RW-1:0] a,
                         input logic [DW-1:0] rf);
    id_src_used[i]          = used;
    id_src_addr[i*RW +: RW] = a;
    rf_data[i*DW +: DW]     = rf;
  endtask

  task automatic set_stg(input int k, input logic en, input logic [RW-1:0] a,
                         input logic [DW-1:0] d, input logic ld);
    stg_wr_en[k]            = en;
    stg_wr_addr[k*RW +: RW] = a;
    stg_wr_data[k*DW +: DW] = d;
    stg_is_load[k]          = ld;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] e1f, e1s, e2f, e2s;
    clr();
    reset = 1'b0;

    // Reset held with a live load-use hazard on the inputs: stall must stay low.
    id_valid = 1'b1;
    set_src(1, 1'b1, 5'd7, 64'h0);
    set_stg(0, 1'b1, 5'd7, 64'h0, 1'b1);
    @(negedge clk);
    chk("rst_stall1", {63'd0, d1_stall}, 64'd0);
    chk("rst_stall2", {63'd0, d2_stall}, 64'd0);
    chk("rst_fcnt2", {32'd0, d2_fcnt}, 64'd0);
    chk("rst_scnt2", {32'd0, d2_scnt}, 64'd0);
    next_cycle();
    clr();
    reset = 1'b1;

    // Youngest stage wins over an older match of the same register.
    next_cycle();
    id_valid = 1'b1;
    set_src(0, 1'b1, 5'd3, 64'h1111);
    set_src(1, 1'b1, 5'd4, 64'h2222);
    set_stg(0, 1'b1, 5'd3, 64'hAA, 1'b0);
    set_stg(1, 1'b1, 5'd3, 64'hBB, 1'b0);
    @(negedge clk);
    chk("prio_a", d2_data[63:0], 64'hAA);
    chk("prio_b", d2_data[127:64], 64'h2222);
    chk("prio_hit", {62'd0, d2_hit}, 64'd1);
    chk("prio_stall", {63'd0, d2_stall}, 64'd0);

    // Zero register is never forwarded and never stalls.
    next_cycle();
    clr();
    id_valid = 1'b1;
    set_src(0, 1'b1, 5'd31, 64'h3333);
    set_src(1, 1'b1, 5'd31, 64'h4444);
    set_stg(0, 1'b1, 5'd31, 64'h55, 1'b0);
    set_stg(1, 1'b1, 5'd31, 64'h66, 1'b1);
    @(negedge clk);
    chk("zero_a", d2_data[63:0], 64'h3333);
    chk("zero_b", d1_data[127:64], 64'h4444);
    chk("zero_hit", {62'd0, d2_hit}, 64'd0);
    chk("zero_stall1", {63'd0, d1_stall}, 64'd0);
    chk("zero_stall2", {63'd0, d2_stall}, 64'd0);

    // Load in stage 0: LOAD_LAT=1 stalls one cycle, LOAD_LAT=2 stalls two.
    next_cycle();
    clr();
    id_valid = 1'b1;
    set_src(1, 1'b1, 5'd7, 64'h7777);
    set_stg(0, 1'b1, 5'd7, 64'hDEAD, 1'b1);
    @(negedge clk);
    chk("ld_c0_stall1", {63'd0, d1_stall}, 64'd1);
    chk("ld_c0_bubble1", {63'd0, d1_bubble}, 64'd1);
    chk("ld_c0_hit1", {62'd0, d1_hit}, 64'd0);
    chk("ld_c0_stall2", {63'd0, d2_stall}, 64'd1);
    next_cycle();
    set_stg(0, 1'b0, 5'd0, 64'h0, 1'b0);
    set_stg(1, 1'b1, 5'd7, 64'h1234, 1'b1);
    @(negedge clk);
    chk("ld_c1_stall1", {63'd0, d1_stall}, 64'd0);
    chk("ld_c1_b1", d1_data[127:64], 64'h1234);
    chk("ld_c1_hit1", {62'd0, d1_hit}, 64'd2);
    chk("ld_c1_stall2", {63'd0, d2_stall}, 64'd1);
    chk("ld_c1_bubble2", {63'd0, d2_bubble}, 64'd1);
    next_cycle();
    set_stg(1, 1'b0, 5'd0, 64'h0, 1'b0);
    set_stg(2, 1'b1, 5'd7, 64'h1234, 1'b1);
    @(negedge clk);
    chk("ld_c2_stall2", {63'd0, d2_stall}, 64'd0);
    chk("ld_c2_b2", d2_data[127:64], 64'h1234);

    // Flush during WAIT drops stall at once and returns to IDLE.
    next_cycle();
    clr();
    id_valid = 1'b1;
    set_src(1, 1'b1, 5'd7, 64'h7777);
    set_stg(0, 1'b1, 5'd7, 64'hDEAD, 1'b1);
    @(negedge clk);
    chk("fl_c0_stall2", {63'd0, d2_stall}, 64'd1);
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_c1_stall2", {63'd0, d2_stall}, 64'd0);
    chk("fl_c1_stall1", {63'd0, d1_stall}, 64'd0);
    next_cycle();
    clr();
    @(negedge clk);
    chk("fl_c2_stall2", {63'd0, d2_stall}, 64'd0);
    // Flush beats a fresh hazard in IDLE: no WAIT afterwards.
    next_cycle();
    id_valid = 1'b1;
    flush    = 1'b1;
    set_src(0, 1'b1, 5'd9, 64'h9);
    set_stg(0, 1'b1, 5'd9, 64'hBEEF, 1'b1);
    @(negedge clk);
    chk("fl_haz_stall2", {63'd0, d2_stall}, 64'd0);
    next_cycle();
    clr();
    @(negedge clk);
    chk("fl_haz_next2", {63'd0, d2_stall}, 64'd0);

    // Asynchronous reset in the middle of WAIT.
    next_cycle();
    id_valid = 1'b1;
    set_src(1, 1'b1, 5'd7, 64'h7777);
    set_stg(0, 1'b1, 5'd7, 64'hDEAD, 1'b1);
    next_cycle();
    #1;
    chk("ar_wait_stall2", {63'd0, d2_stall}, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_stall2", {63'd0, d2_stall}, 64'd0);
    chk("ar_stall1", {63'd0, d1_stall}, 64'd0);
    chk("ar_fcnt1", {32'd0, d1_fcnt}, 64'd0);
    chk("ar_scnt2", {32'd0, d2_scnt}, 64'd0);
    next_cycle();
    clr();
    reset = 1'b1;
    @(negedge clk);
    chk("ar_idle2", {63'd0, d2_stall}, 64'd0);

    // Statistics: three dual forwards, then one single-cycle stall on LOAD_LAT=2.
    for (int n = 0; n < 3; n++) begin
      next_cycle();
      id_valid = 1'b1;
      set_src(0, 1'b1, 5'd10, 64'h1);
      set_src(1, 1'b1, 5'd11, 64'h2);
      set_stg(0, 1'b1, 5'd10, 64'h100 + 64'(n), 1'b0);
      set_stg(1, 1'b1, 5'd11, 64'h200 + 64'(n), 1'b0);
      @(negedge clk);
      chk("st_dual_hit", {62'd0, d2_hit}, 64'd3);
    end
    next_cycle();
    clr();
    id_valid = 1'b1;
    set_src(0, 1'b1, 5'd12, 64'h3);
    set_stg(1, 1'b1, 5'd12, 64'hC0DE, 1'b1);
    @(negedge clk);
    chk("st_k1_stall2", {63'd0, d2_stall}, 64'd1);
    chk("st_k1_stall1", {63'd0, d1_stall}, 64'd0);
    chk("st_k1_a1", d1_data[63:0], 64'hC0DE);
    next_cycle();
    clr();
    @(negedge clk);
    chk("st_k1_after2", {63'd0, d2_stall}, 64'd0);
`ifdef FWD_STATS_EN
    e2f = 32'd6; e2s = 32'd1; e1f = 32'd7; e1s = 32'd0;
`else
    e2f = 32'd0; e2s = 32'd0; e1f = 32'd0; e1s = 32'd0;
`endif
    chk("st_fcnt2", {32'd0, d2_fcnt}, {32'd0, e2f});
    chk("st_scnt2", {32'd0, d2_scnt}, {32'd0, e2s});
    chk("st_fcnt1", {32'd0, d1_fcnt}, {32'd0, e1f});
    chk("st_scnt1", {32'd0, d1_scnt}, {32'd0, e1s});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
